// File: rtl/usr_seq_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module   : usr_seq_ctrl                                               |
// | Function : expands load/shift/rotate/ASR commands into mode cycles    |
// |            for a 4-bit universal shift register                       |
// | Revision : 1.0 - initial release                                      |
// +-----------------------------------------------------------------------+
module usr_seq_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [2:0] cmd_op,
  input  logic [1:0] cmd_cnt,
  input  logic [3:0] cmd_data,
  input  logic [3:0] usr_q,
  output logic [1:0] usr_s,
  output logic [3:0] usr_i,
  output logic       usr_sinl,
  output logic       usr_sinr,
  output logic       busy,
  output logic       done,
  output logic       cmd_err
);

  localparam logic [2:0] C_OP_LOAD = 3'b000;
  localparam logic [2:0] C_OP_SHL  = 3'b001;
  localparam logic [2:0] C_OP_SHR  = 3'b010;
  localparam logic [2:0] C_OP_ROL  = 3'b011;
  localparam logic [2:0] C_OP_ROR  = 3'b100;
  localparam logic [2:0] C_OP_ASR  = 3'b101;

  localparam logic [1:0] C_MODE_LOAD = 2'b00;
  localparam logic [1:0] C_MODE_UP   = 2'b01;
  localparam logic [1:0] C_MODE_DOWN = 2'b10;
  localparam logic [1:0] C_MODE_HOLD = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t     r_state;
  state_t     w_next;
  logic [2:0] r_op;
  logic [3:0] r_data;
  logic [2:0] r_rem;
  logic       r_err;
  logic       w_accept;
  logic       w_illegal;

  assign cmd_ready = (r_state == IDLE) & ~reset;
  assign w_accept  = cmd_valid & cmd_ready;
  assign w_illegal = cmd_op[2] & cmd_op[1];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Command fields are captured only on the accept edge; r_rem counts
  // the EXEC cycles still to run, including the current one.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_op   <= 3'd0;
      r_data <= 4'd0;
      r_rem  <= 3'd0;
      r_err  <= 1'b0;
    end else if (w_accept) begin
      r_op   <= cmd_op;
      r_data <= cmd_data;
      r_err  <= w_illegal;
      if (w_illegal) begin
        r_rem <= 3'd0;
      end else if (cmd_op == C_OP_LOAD) begin
        r_rem <= 3'd1;
      end else begin
        r_rem <= {1'b0, cmd_cnt} + 3'd1;
      end
    end else if ((r_state == EXEC) && (r_rem != 3'd0)) begin
      r_rem <= r_rem - 3'd1;
    end
  end

  always_comb begin
    w_next   = r_state;
    busy     = (r_state != IDLE);
    done     = 1'b0;
    cmd_err  = 1'b0;
    usr_s    = C_MODE_HOLD;
    usr_i    = 4'd0;
    usr_sinl = 1'b0;
    usr_sinr = 1'b0;

    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_next = w_illegal ? FIN : EXEC;
        end
      end

      EXEC: begin
        if (r_rem <= 3'd1) begin
          w_next = FIN;
        end
        // Fill bits come straight from usr_q so each repeat sees the
        // value written by the previous edge.
        case (r_op)
          C_OP_LOAD: begin
            usr_s = C_MODE_LOAD;
            usr_i = r_data;
          end
          C_OP_SHL: begin
            usr_s    = C_MODE_UP;
            usr_sinl = 1'b0;
          end
          C_OP_SHR: begin
            usr_s    = C_MODE_DOWN;
            usr_sinr = 1'b0;
          end
          C_OP_ROL: begin
            usr_s    = C_MODE_UP;
            usr_sinl = usr_q[3];
          end
          C_OP_ROR: begin
            usr_s    = C_MODE_DOWN;
            usr_sinr = usr_q[0];
          end
          C_OP_ASR: begin
            usr_s    = C_MODE_DOWN;
            usr_sinr = usr_q[3];
          end
          default: begin
            usr_s = C_MODE_HOLD;
          end
        endcase
      end

      FIN: begin
        w_next  = IDLE;
        // An aborted command must not report completion.
        done    = ~reset;
        cmd_err = r_err & ~reset;
      end

      default: begin
        w_next = IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_usr_seq_ctrl.sv
`default_nettype none
// Bench for usr_seq_ctrl: a behavioural shift register closes the feedback
// loop; results are compared against an arithmetic command model.
module tb_usr_seq_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [2:0] cmd_op = 3'd0;
  logic [1:0] cmd_cnt = 2'd0;
  logic [3:0] cmd_data = 4'd0;
  logic [3:0] usr_q;
  logic [1:0] usr_s;
  logic [3:0] usr_i;
  logic       usr_sinl;
  logic       usr_sinr;
  logic       busy;
  logic       done;
  logic       cmd_err;

  int nvec = 0;
  int nerr = 0;
  logic [3:0] mq;

  always #5 clk = ~clk;

  usr_seq_ctrl dut (
    .clk      (clk),
    .reset    (reset),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_op   (cmd_op),
    .cmd_cnt  (cmd_cnt),
    .cmd_data (cmd_data),
    .usr_q    (usr_q),
    .usr_s    (usr_s),
    .usr_i    (usr_i),
    .usr_sinl (usr_sinl),
    .usr_sinr (usr_sinr),
    .busy     (busy),
    .done     (done),
    .cmd_err  (cmd_err)
  );

  // Downstream universal shift register sharing clock and reset.
  always @(posedge clk) begin
    if (reset) usr_q <= 4'd0;
    else begin
      case (usr_s)
        2'b00:   usr_q <= usr_i;
        2'b01:   usr_q <= {usr_q[2:0], usr_sinl};
        2'b10:   usr_q <= {usr_sinr, usr_q[3:1]};
        default: usr_q <= usr_q;
      endcase
    end
  end

  typedef struct {
    logic [2:0] op;
    logic [1:0] cnt;
    logic [3:0] data;
    logic [3:0] exp_q;
  } vec_t;

  vec_t tbl[12];

  function automatic logic [3:0] step(input logic [2:0] op, input logic [3:0] d, input logic [3:0] v);
    int x;
    x = int'(v);
    case (op)
      3'd0: x = int'(d);
      3'd1: x = (x * 2) % 16;
      3'd2: x = x / 2;
      3'd3: x = (x * 2) % 16 + x / 8;
      3'd4: x = x / 2 + (x % 2) * 8;
      3'd5: x = x / 2 + (x / 8) * 8;
      default: x = x;
    endcase
    return 4'(x);
  endfunction

  function automatic logic [1:0] mode_of(input logic [2:0] op);
    if (op == 3'd0) return 2'b00;
    if (op == 3'd1 || op == 3'd3) return 2'b01;
    return 2'b10;
  endfunction

  function automatic int nshifts(input logic [2:0] op, input logic [1:0] cnt);
    if (op >= 3'd6) return 0;
    if (op == 3'd0) return 1;
    return int'(cnt) + 1;
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Called at a negedge; returns at the negedge of the IDLE cycle after FIN.
  task automatic run_cmd(input logic [2:0] op, input logic [1:0] cnt, input logic [3:0] data,
                         input logic [3:0] exp_q);
    int n;
    int t;
    logic ill;
    n   = nshifts(op, cnt);
    ill = (op >= 3'd6);
    t   = 0;
    while (!cmd_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("ready_before_cmd", 8'(cmd_ready), 8'd1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_cnt   = cnt;
    cmd_data  = data;
    @(posedge clk);
    #1;
    cmd_op    = 3'($urandom_range(0, 7));
    cmd_cnt   = 2'($urandom_range(0, 3));
    cmd_data  = 4'($urandom_range(0, 15));
    cmd_valid = 1'($urandom_range(0, 1));
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check("exec_busy_done_mode", 8'({busy, done, usr_s}), 8'({1'b1, 1'b0, mode_of(op)}));
      mq = step(op, data, mq);
      @(posedge clk);
      #1;
      check("reg_after_step", 8'(usr_q), 8'(mq));
    end
    @(negedge clk);
    check("fin_busy_done_err_mode", 8'({busy, done, cmd_err, usr_s}), 8'({1'b1, 1'b1, ill, 2'b11}));
    cmd_valid = 1'b0;
    @(negedge clk);
    check("idle_busy_done_ready", 8'({busy, done, cmd_ready}), 8'b001);
    check("final_reg", 8'(usr_q), 8'(exp_q));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] f;
    logic [2:0] rop;
    logic [1:0] rcnt;
    logic [3:0] rdata;

    tbl[0]  = '{3'd0, 2'd0, 4'b1011, 4'b1011};
    tbl[1]  = '{3'd3, 2'd1, 4'b0000, 4'b1110};
    tbl[2]  = '{3'd0, 2'd2, 4'b1000, 4'b1000};
    tbl[3]  = '{3'd5, 2'd3, 4'b0000, 4'b1111};
    tbl[4]  = '{3'd0, 2'd0, 4'b0110, 4'b0110};
    tbl[5]  = '{3'd2, 2'd0, 4'b1111, 4'b0011};
    tbl[6]  = '{3'd4, 2'd0, 4'b0000, 4'b1001};
    tbl[7]  = '{3'd7, 2'd3, 4'b0101, 4'b1001};
    tbl[8]  = '{3'd1, 2'd2, 4'b0000, 4'b1000};
    tbl[9]  = '{3'd6, 2'd1, 4'b1111, 4'b1000};
    tbl[10] = '{3'd4, 2'd3, 4'b0000, 4'b1000};
    tbl[11] = '{3'd0, 2'd1, 4'b0001, 4'b0001};

    // Reset held with a pending command
    reset     = 1'b1;
    cmd_valid = 1'b1;
    cmd_op    = 3'd0;
    cmd_data  = 4'hF;
    repeat (2) begin
      @(negedge clk);
      check("reset_ready_busy_done_err_mode", 8'({cmd_ready, busy, done, cmd_err, usr_s}), 8'b000011);
      check("reset_i_sinl_sinr", 8'({usr_i, usr_sinl, usr_sinr}), 8'd0);
    end
    cmd_valid = 1'b0;
    reset     = 1'b0;
    mq        = 4'd0;
    @(negedge clk);
    check("post_reset_ready_done_busy", 8'({cmd_ready, done, busy}), 8'b100);
    check("post_reset_reg", 8'(usr_q), 8'd0);

    foreach (tbl[k]) run_cmd(tbl[k].op, tbl[k].cnt, tbl[k].data, tbl[k].exp_q);

    // Reset during the second EXEC cycle of SHL x4 from 0001
    cmd_valid = 1'b1;
    cmd_op    = 3'd1;
    cmd_cnt   = 2'd3;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    @(posedge clk);
    #1;
    check("abort_reg_after_first", 8'(usr_q), 8'b0010);
    reset = 1'b1;
    @(negedge clk);
    check("abort_in_exec_busy_done_mode", 8'({busy, done, usr_s}), 8'b1001);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("abort_idle_outputs", 8'({busy, done, cmd_err, cmd_ready, usr_s}), 8'b000011);
    check("abort_reg_cleared", 8'(usr_q), 8'd0);
    reset = 1'b0;
    mq    = 4'd0;
    repeat (3) begin
      @(negedge clk);
      check("abort_no_done", 8'({done, cmd_err, busy, cmd_ready}), 8'b0001);
    end

    // Randomized commands against the arithmetic model
    for (int r = 0; r < 40; r++) begin
      rop   = 3'($urandom_range(0, 7));
      rcnt  = 2'($urandom_range(0, 3));
      rdata = 4'($urandom_range(0, 15));
      f     = mq;
      for (int s = 0; s < nshifts(rop, rcnt); s++) f = step(rop, rdata, f);
      run_cmd(rop, rcnt, rdata, f);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/usr_seq_ctrl.md
# usr_seq_ctrl

Command sequencer that sits directly upstream of the 4-bit universal shift register and drives its mode select, parallel input and serial inputs. It accepts one command at a time over a valid/ready handshake and expands each command into the correct sequence of mode cycles. Supported commands are parallel load, logical shifts, rotates and arithmetic shift right, with a repeat count of 1–4. Rotate and arithmetic fill bits come from the register's current output, which is fed back into this block.

## Interface
Parameters:
- none; data width is fixed at 4.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high; one clock, one reset shared with the shift register.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block can accept a command; equals (state==IDLE) & ~reset.
- cmd_op  in  3  opcode: 000 LOAD, 001 SHL, 010 SHR, 011 ROL, 100 ROR, 101 ASR, 110/111 illegal.
- cmd_cnt  in  2  repeat count minus 1 (shifts = cmd_cnt+1); ignored for LOAD.
- cmd_data  in  4  parallel word for LOAD.
- usr_q  in  4  current shift-register output (feedback).
- usr_s  out  2  mode to register: 00 parallel load, 01 shift toward MSB (SINL enters bit 0), 10 shift toward LSB (SINR enters bit 3), 11 hold.
- usr_i  out  4  parallel data to register.
- usr_sinl  out  1  serial bit entering bit 0.
- usr_sinr  out  1  serial bit entering bit 3.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse when a command completes.
- cmd_err  out  1  one-cycle pulse, coincident with done, for an illegal opcode.

## Operation
- FSM states:
  - IDLE: usr_s=11; cmd_ready=1.
  - EXEC: drives the opcode's mode each cycle.
  - FIN: 1 cycle; done=1; usr_s=11.
- Transitions:
  - IDLE→EXEC on cmd_valid & cmd_ready. On that edge, latch op, data, and remaining = cnt+1 (LOAD: 1).
  - EXEC stays while remaining>1 and decrements each edge.
  - EXEC→FIN when remaining==1.
  - FIN→IDLE unconditionally.
  - Illegal opcode: IDLE→FIN directly, with cmd_err=1; usr_s stays 11 and no register change.
- Drive in EXEC (combinational from latched op and usr_q):
  - LOAD: usr_s=00, usr_i=latched data.
  - SHL: usr_s=01, sinl=0.
  - SHR: usr_s=10, sinr=0.
  - ROL: usr_s=01, sinl=usr_q[3].
  - ROR: usr_s=10, sinr=usr_q[0].
  - ASR: usr_s=10, sinr=usr_q[3].
- Outside EXEC: usr_i=0, usr_sinl=0, usr_sinr=0, usr_s=11.
- cmd_valid is ignored while busy; no queueing.
- cmd_op, cmd_cnt and cmd_data are sampled only at the accept edge; later changes have no effect.

## Timing
- Reset values: state=IDLE, usr_s=11, usr_i=0, usr_sinl=0, usr_sinr=0, busy=0, done=0, cmd_err=0, remaining=0. cmd_ready=0 while reset is high.
- Reset mid-EXEC or in FIN: next cycle is IDLE; no done or cmd_err pulse is produced for the aborted command.
- Latency, with accept at edge A: EXEC occupies cycles A+1 .. A+N, where N = number of shifts (1 for LOAD). The register updates at each of those edges. done is high in cycle A+N+1 (FIN). The next command can be accepted at the edge ending cycle A+N+2 (IDLE).
- Illegal opcode: done and cmd_err are high in cycle A+1; IDLE from cycle A+2.
- Throughput:
  - LOAD: one command per 3 cycles.
  - 4-shift command: one per 6 cycles.
- Rotate and ASR fill use usr_q as seen in the same cycle, so every repeat sees the updated value.

## Test plan
- Reset: hold reset 2 cycles with cmd_valid=1 → cmd_ready=0, usr_s=11, no accept. After release → cmd_ready=1, done=0.
- LOAD then ROL: LOAD 1011, then ROL cnt=1 (2 shifts) → register reads 1011 after load, 0111 after the first shift, 1110 after the second. done pulses once per command; exactly 2 EXEC cycles for the ROL.
- ASR: register holds 1000, ASR cnt=3 → sequence 1100, 1110, 1111, 1111. done in cycle A+5.
- SHR/ROR: from 0110, SHR cnt=0 → 0011. Then ROR cnt=0 → 1001.
- Illegal op 111: → cmd_err=1 and done=1 in cycle A+1. Register value unchanged; usr_s=11 throughout.
- Reset mid-operation: SHL cnt=3 from 0001, reset asserted during the 2nd EXEC cycle → state IDLE and register 0000 next cycle. No done pulse; cmd_ready returns 1 after reset drops.
